conv_window_buffer: RTL and testbench

Streaming sliding-window generator feeding the convolutional layer's combinational inner-product stage. Accepts a raster-order pixel stream one element per cycle and emits each full K×K window as one packed vector, element i at bits [D_WIDTH*(i+1)-1 : D_WIDTH*i]. Windows are valid-only, with no padding: (IMG_WIDTH-K+1)*(IMG_HEIGHT-K+1) windows per frame. Rows are held in K-1 on-chip line buffers.

---
 rtl/conv_window_buffer.sv | 139 +++++++++++++
 tb/tb_conv_window_buffer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_buffer.sv
// conv_window_buffer: streaming K x K sliding-window generator.
// Raster pixels enter one per cycle. K-1 cascaded line buffers supply the
// older rows, and each complete valid-only window is emitted as one packed
// vector through a single output register.
module conv_window_buffer #(
   parameter int D_WIDTH    = 8,
   parameter int K          = 3,
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic [D_WIDTH-1:0]       in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [D_WIDTH*K*K-1:0]   out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     frame_done
);

   localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] COL_WIN   = CW'(K - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [RW-1:0] ROW_PRE   = RW'(K - 2);

   typedef enum logic {FILL, STREAM} state_t;

   state_t               r_state;
   logic [CW-1:0]        r_col;
   logic [RW-1:0]        r_row;
   logic [D_WIDTH-1:0]   r_lb  [K-1][IMG_WIDTH];
   logic [D_WIDTH-1:0]   r_win [K][K];

   logic [D_WIDTH-1:0]     w_win_next [K][K];
   logic [D_WIDTH*K*K-1:0] w_pack;
   logic                   w_accept;
   logic                   w_produce;
   logic                   w_col_last;
   logic                   w_row_last;

   assign in_ready   = !out_valid || out_ready;
   assign w_accept   = in_valid && in_ready && !clear;
   assign w_col_last = (r_col == COL_LAST);
   assign w_row_last = (r_row == ROW_LAST);
   assign w_produce  = w_accept && (r_state == STREAM) && (r_col >= COL_WIN);

   // Next window: shift every row left, load new right column
   // (line-buffer tails oldest row first, then the incoming pixel).
   always_comb begin
      w_win_next = r_win;
      for (int unsigned r = 0; r < K; r++) begin
         for (int unsigned c = 0; c < K - 1; c++) begin
            w_win_next[r][c] = r_win[r][c+1];
         end
      end
      for (int unsigned r = 0; r < K - 1; r++) begin
         w_win_next[r][K-1] = r_lb[K-2-r][IMG_WIDTH-1];
      end
      w_win_next[K-1][K-1] = in_data;
   end

   // Flatten the next window so element r*K+c sits at slice r*K+c.
   always_comb begin
      w_pack = '0;
      for (int unsigned r = 0; r < K; r++) begin
         for (int unsigned c = 0; c < K; c++) begin
            w_pack[(r*K+c)*D_WIDTH +: D_WIDTH] = w_win_next[r][c];
         end
      end
   end

   // Cascaded row FIFOs; buffer j's tail feeds buffer j+1's head.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_lb[0][0] <= in_data;
         for (int unsigned j = 1; j < K - 1; j++) begin
            r_lb[j][0] <= r_lb[j-1][IMG_WIDTH-1];
         end
         for (int unsigned j = 0; j < K - 1; j++) begin
            for (int unsigned i = 1; i < IMG_WIDTH; i++) begin
               r_lb[j][i] <= r_lb[j][i-1];
            end
         end
      end
   end

   // Window register advances on every accepted pixel.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_win <= w_win_next;
      end
   end

   // Position counters, FILL/STREAM control and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= FILL;
         r_col      <= '0;
         r_row      <= '0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         frame_done <= 1'b0;
      end else if (clear) begin
         r_state    <= FILL;
         r_col      <= '0;
         r_row      <= '0;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= w_accept && w_col_last && w_row_last;
         if (w_produce) begin
            out_data  <= w_pack;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (w_accept) begin
            if (w_col_last) begin
               r_col <= '0;
               if (w_row_last) r_row <= '0;
               else            r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
            case (r_state)
               FILL:   if (w_col_last && (r_row == ROW_PRE)) r_state <= STREAM;
               STREAM: if (w_col_last && w_row_last)         r_state <= FILL;
               default: r_state <= FILL;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conv_window_buffer.sv
// tb_conv_window_buffer: directed and randomized checks of conv_window_buffer
// against a frame-store reference model (K=3, 4x4 image, 8-bit pixels).
module tb_conv_window_buffer;

   localparam int DW = 8;
   localparam int K  = 3;
   localparam int W  = 4;
   localparam int H  = 4;
   localparam int OW = DW*K*K;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [OW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          frame_done;

   conv_window_buffer #(.D_WIDTH(DW), .K(K), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: frame store plus expected output register state.
   int            m_row, m_col;
   logic          m_valid, m_fd;
   logic [OW-1:0] m_data;
   logic [DW-1:0] img [H][W];
   logic [OW-1:0] wins [$];
   int            fd_count;

   task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [OW-1:0] mk(input int unsigned e [K*K]);
      logic [OW-1:0] v;
      logic [31:0]   t;
      v = '0;
      for (int i = 0; i < K*K; i++) begin
         t = e[i];
         v[i*DW +: DW] = t[DW-1:0];
      end
      return v;
   endfunction

   task automatic model_reset();
      m_row = 0; m_col = 0; m_valid = 1'b0; m_fd = 1'b0; m_data = '0;
   endtask

   // One clock cycle: drive inputs, check in_ready, advance model, check outputs.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy,
                       input logic clr, output logic acc);
      logic m_rdy, m_new, fd_next;
      in_valid = v; in_data = d; out_ready = rdy; clear = clr;
      #1;
      m_rdy = !m_valid || rdy;
      chk("in_ready", {{(OW-1){1'b0}}, in_ready}, {{(OW-1){1'b0}}, m_rdy});
      acc = v && m_rdy && !clr;
      m_new = 1'b0; fd_next = 1'b0;
      if (clr) begin
         m_row = 0; m_col = 0; m_valid = 1'b0; m_fd = 1'b0;
      end else begin
         if (acc) begin
            img[m_row][m_col] = d;
            if (m_row >= K-1 && m_col >= K-1) begin
               for (int r = 0; r < K; r++)
                  for (int c = 0; c < K; c++)
                     m_data[(r*K+c)*DW +: DW] = img[m_row-K+1+r][m_col-K+1+c];
               m_new = 1'b1;
            end
            if (m_col == W-1) begin
               m_col = 0;
               if (m_row == H-1) begin m_row = 0; fd_next = 1'b1; end
               else m_row = m_row + 1;
            end else begin
               m_col = m_col + 1;
            end
         end
         m_valid = m_new ? 1'b1 : (rdy ? 1'b0 : m_valid);
         m_fd = fd_next;
      end
      @(posedge clk);
      #1;
      chk("out_valid", {{(OW-1){1'b0}}, out_valid}, {{(OW-1){1'b0}}, m_valid});
      chk("frame_done", {{(OW-1){1'b0}}, frame_done}, {{(OW-1){1'b0}}, m_fd});
      if (m_valid) chk("out_data", out_data, m_data);
      if (m_new) wins.push_back(out_data);
      if (m_fd) fd_count++;
   endtask

   task automatic send_frame(input int base);
      logic acc;
      for (int p = 0; p < W*H; p++) step(1'b1, DW'(base + p), 1'b1, 1'b0, acc);
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
   endtask

   initial begin
      logic [OW-1:0] B [4];
      logic [OW-1:0] F2;
      logic          acc;
      int            p, hold, guard, cnt;

      B[0] = mk('{0,1,2,4,5,6,8,9,10});
      B[1] = mk('{1,2,3,5,6,7,9,10,11});
      B[2] = mk('{4,5,6,8,9,10,12,13,14});
      B[3] = mk('{5,6,7,9,10,11,13,14,15});
      F2   = mk('{100,101,102,104,105,106,108,109,110});

      // Reset state
      model_reset();
      #1;
      chk("rst_out_valid", {{(OW-1){1'b0}}, out_valid}, '0);
      chk("rst_out_data", out_data, '0);
      chk("rst_frame_done", {{(OW-1){1'b0}}, frame_done}, '0);
      chk("rst_in_ready", {{(OW-1){1'b0}}, in_ready}, {{(OW-1){1'b0}}, 1'b1});
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Basic frame
      wins.delete(); fd_count = 0;
      send_frame(0);
      idle(3);
      chk("basic_count", OW'(wins.size()), OW'(4));
      chk("basic_fd", OW'(fd_count), OW'(1));
      for (int i = 0; i < 4 && i < wins.size(); i++) chk($sformatf("basic_win%0d", i), wins[i], B[i]);

      // Backpressure: 5 stalled cycles after the first window
      wins.delete(); fd_count = 0;
      p = 0; hold = -1; guard = 0;
      while (p < W*H && guard < 200) begin
         step(1'b1, DW'(p), (hold > 0) ? 1'b0 : 1'b1, 1'b0, acc);
         if (hold > 0) begin
            chk("bp_hold_data", out_data, B[0]);
            chk("bp_in_ready", {{(OW-1){1'b0}}, in_ready}, '0);
            hold--;
         end
         if (acc) p++;
         if (hold < 0 && wins.size() == 1) hold = 5;
         guard++;
      end
      if (guard >= 200) chk("bp_timeout", OW'(p), OW'(W*H));
      idle(3);
      chk("bp_count", OW'(wins.size()), OW'(4));
      for (int i = 0; i < 4 && i < wins.size(); i++) chk($sformatf("bp_win%0d", i), wins[i], B[i]);

      // Back-to-back frames
      wins.delete(); fd_count = 0;
      send_frame(0);
      send_frame(100);
      idle(3);
      chk("b2b_count", OW'(wins.size()), OW'(8));
      chk("b2b_fd", OW'(fd_count), OW'(2));
      if (wins.size() > 4) chk("b2b_f2_first", wins[4], F2);

      // clear mid-frame, then restart
      wins.delete(); fd_count = 0;
      for (int i = 0; i < 10; i++) step(1'b1, DW'(i), 1'b1, 1'b0, acc);
      step(1'b1, 8'hAA, 1'b1, 1'b1, acc);
      send_frame(0);
      idle(3);
      chk("clr_count", OW'(wins.size()), OW'(4));
      for (int i = 0; i < 4 && i < wins.size(); i++) chk($sformatf("clr_win%0d", i), wins[i], B[i]);

      // Randomized traffic: three frames with random valid/ready gaps
      wins.delete(); fd_count = 0;
      cnt = 0; guard = 0;
      while (cnt < 3*W*H && guard < 3000) begin
         step($urandom_range(0, 3) != 0, DW'($urandom_range(0, 255)),
              $urandom_range(0, 2) != 0, 1'b0, acc);
         if (acc) cnt++;
         guard++;
      end
      if (guard >= 3000) chk("rnd_timeout", OW'(cnt), OW'(3*W*H));
      idle(3);
      chk("rnd_count", OW'(wins.size()), OW'(12));
      chk("rnd_fd", OW'(fd_count), OW'(3));

      // Asynchronous reset while a window is held
      for (int i = 0; i < 11; i++) step(1'b1, DW'(i), 1'b1, 1'b0, acc);
      step(1'b0, '0, 1'b0, 1'b0, acc);
      chk("ar_pre_valid", {{(OW-1){1'b0}}, out_valid}, {{(OW-1){1'b0}}, 1'b1});
      #2 rst_n = 1'b0;
      #1;
      chk("ar_out_valid", {{(OW-1){1'b0}}, out_valid}, '0);
      chk("ar_out_data", out_data, '0);
      chk("ar_frame_done", {{(OW-1){1'b0}}, frame_done}, '0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("ar_in_ready", {{(OW-1){1'b0}}, in_ready}, {{(OW-1){1'b0}}, 1'b1});
      wins.delete(); fd_count = 0;
      send_frame(0);
      idle(3);
      chk("ar_count", OW'(wins.size()), OW'(4));
      for (int i = 0; i < 4 && i < wins.size(); i++) chk($sformatf("ar_win%0d", i), wins[i], B[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
